// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: 8N1 asynchronous serial receiver.
//   Deserialises start + 8 data bits (LSB first) + 1 stop bit from rx, holds
//   the last good byte with a sticky valid/ack handshake, and flags framing
//   errors and overruns. Bit timing is derived from freq/baud
//   (C = freq/baud clocks per bit, sampled at H = C/2 into each bit).
// Parameters:
//   freq      system clock frequency in Hz
//   baud      line bit rate
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   rx        serial line, idle high, asynchronous to clk
//   ack       consumer took data; clears valid and overrun
//   data      last good byte received
//   valid     sticky, set on frame completion, cleared by ack
//   frame_err one-cycle pulse when the stop bit samples low
//   overrun   sticky, a byte completed while valid was already high
//   busy      receiver is not idle
// Build option:
//   UART_RX_MAJORITY_EN  each sample is the 2-of-3 majority of rx_s over the
//                        nominal sample cycle and the two cycles before it.
module uart_rx #(
    parameter int unsigned freq = 27000000,
    parameter int unsigned baud = 3000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       ack,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned CLKS_PER_BIT = freq / baud;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = 8;
    localparam int unsigned IDX_W        = 3;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             busy_q, busy_d;

    logic rx_meta_q, rx_s_q, rx_d_q;
    logic sample_bit;

    // Two-flop synchroniser plus edge register; idle-high after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_d_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_d_q    <= rx_s_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic rx_h1_q, rx_h2_q;

    // History of rx_s for the 2-of-3 vote.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_h1_q <= 1'b1;
            rx_h2_q <= 1'b1;
        end else begin
            rx_h1_q <= rx_s_q;
            rx_h2_q <= rx_h1_q;
        end
    end

    assign sample_bit = (rx_s_q & rx_h1_q) | (rx_s_q & rx_h2_q) | (rx_h1_q & rx_h2_q);
`else
    assign sample_bit = rx_s_q;
`endif

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q;

        // ack is applied first so a coinciding completion overrides it.
        if (ack) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // Only a true 1->0 transition starts a frame, never a held-low line.
                if (rx_d_q && !rx_s_q) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!sample_bit) begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = sample_bit;
                    if (idx_q == IDX_W'(7)) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (sample_bit) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        if (valid_q && !ack) begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver: the downstream partner of the UART transmitter. It deserialises 8N1 frames (start bit, 8 data bits LSB first, one stop bit) from a single input line, presents each received byte with a sticky valid/acknowledge handshake, and flags framing errors and overruns. It uses the same `freq`/`baud` parameterisation as the transmitter, so a TX→RX loopback on one clock is bit-exact.

## Interface
- `freq`, 27000000: system clock frequency in Hz.
- `baud`, 3000000: line bit rate. `C = freq / baud` (integer division) clocks per bit; 4 ≤ C ≤ 255. `H = C / 2`.
- `clk` input 1: system clock. All logic on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `rx` input 1: serial line, idle high, asynchronous to `clk`.
- `ack` input 1: consumer has taken `data`; clears `valid` and `overrun`.
- `data` output 8: last good byte received.
- `valid` output 1: sticky; high from frame completion until `ack`.
- `frame_err` output 1: one-cycle pulse when a stop bit samples low.
- `overrun` output 1: sticky; set when a byte completes while `valid` is already high.
- `busy` output 1: high in any state other than IDLE.

## Operation
- Reset: the synchroniser flops are set to 1, the FSM goes to IDLE, and the counters are cleared. Outputs are `data=8'h00`, `valid=0`, `frame_err=0`, `overrun=0`, `busy=0`. Reset mid-frame discards the partial byte, and nothing is emitted.
- `rx` passes through a 2-flop synchroniser to give `rx_s`. An edge register `rx_d` holds the previous `rx_s`.
- FSM states: IDLE, START, DATA, STOP.
  - **IDLE:** a falling edge (`rx_d=1`, `rx_s=0`) loads the bit counter with 0 and moves to START. A line that is merely held low (break, or after a framing error) does not trigger a frame. A new rising then falling edge is required.
  - **START:** the line is sampled H clocks after the edge. If it samples 0, go to DATA with the bit index at 0. If it samples 1, this is a false start: return to IDLE with no outputs changed.
  - **DATA:** the line is sampled every C clocks after the start sample. Each sample shifts into bit[index], LSB first. After index 7, go to STOP.
  - **STOP:** the line is sampled C clocks after data bit 7.
    - If it samples 1: on the next edge `data` is loaded and `valid` is set. If `valid` was already high and `ack` is low in that cycle, `overrun` is also set, and `data` is overwritten with the new byte.
    - If it samples 0: pulse `frame_err` for one cycle. `data`, `valid` and `overrun` are unchanged.
    - In both cases, return to IDLE.
- `ack` clears `valid` and `overrun` on the next edge. If `ack` coincides with a frame completion, the completion wins: `valid` stays 1 with the new byte, and `overrun` is not set.
- `ack` while `valid=0` has no effect.
- The bit-clock counter is 8 bits wide and compares against constants derived from `freq`/`baud`. No division is performed in hardware.

## Timing
- Let t0 be the first cycle with `rx_s=0` after `rx_s=1`. The line fall precedes t0 by 2 clocks because of the synchroniser.
- Sample points relative to t0:
  - start bit at t0+H;
  - data bit k at t0+H+(k+1)·C;
  - stop bit at t0+H+9·C.
- `valid` or `frame_err` rises one cycle after the stop sample. With the defaults (C=9, H=4), the stop sample is at t0+85 and `valid` rises at t0+86.
- IDLE is re-entered in the same cycle that `valid` rises, so a start edge half a bit later is accepted. Back-to-back frames from the transmitter are received with no gap.

## Configuration
- `UART_RX_MAJORITY_EN`:
  - **Defined:** every sample (start, data, stop) is the 2-of-3 majority of `rx_s` at the nominal sample cycle and the two cycles before it. Sample times are unchanged. Two extra history flops are added.
  - **Undefined:** every sample is the single `rx_s` value at the nominal sample cycle.

## Test plan
- **Reset:** hold `rst_n=0` with `rx` toggling, then release. All outputs must hold reset values and no frame may start until a fresh falling edge arrives.
- **Loopback:** send byte 8'hA5 at C=9 with `ack=0`. Require `data=8'hA5` and `valid=1` at t0+86, `frame_err=0` and `busy=0` afterwards. Then pulse `ack` and require `valid=0`.
- **False start:** drive `rx` low for 3 clocks, then high. Require a return to IDLE with no `valid`, no `frame_err`, and `busy` low by t0+5.
- **Framing error:** send 8'h3C with the stop bit forced to 0. Require a one-cycle `frame_err` at t0+86 with `data` and `valid` unchanged. Then hold `rx` low for 20 bits and require no new frame.
- **Overrun and collision:**
  - Send 8'h11 then 8'h22 back-to-back with no `ack`. Require `overrun=1` and `data=8'h22`.
  - Repeat with `ack` asserted in the completion cycle of the second byte. Require `valid=1` and `overrun=0`.
- **Mid-frame reset and majority:** assert `rst_n=0` at data bit 4, then release; require no output activity. With `UART_RX_MAJORITY_EN` defined, inject a 1-clock glitch at the sample cycle of bit 2 of 8'h00; require `data=8'h00`.
